// File: rtl/serial_shifter_32.sv
// Multi-cycle 32-bit shifter: SLL/SRL/SRA one bit per clock, registered result with a done pulse.
// Optional SERIAL_SHIFTER_ROTATE_EN turns op=11 into ROTR; otherwise op=11 is a one-cycle pass-through.
module serial_shifter_32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [4:0]  amt,
    input  logic [31:0] in,
    output logic [31:0] f,
    output logic        busy,
    output logic        done,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    logic [1:0]  state;
    logic [1:0]  op_q;
    logic [4:0]  cnt;
    logic [4:0]  eff_amt;
    logic [31:0] step;

    // Handshake: start is a request that is taken only while busy=0 (IDLE);
    // a start seen in SHIFT or DONE is dropped, never queued.
`ifdef SERIAL_SHIFTER_ROTATE_EN
    assign eff_amt = amt;
`else
    assign eff_amt = (op == 2'b11) ? 5'd0 : amt;
`endif

    always_comb begin
        step = f;
        case (op_q)
            OP_SLL:  step = {f[30:0], 1'b0};
            OP_SRL:  step = {1'b0, f[31:1]};
            OP_SRA:  step = {f[31], f[31:1]};
            default: begin
`ifdef SERIAL_SHIFTER_ROTATE_EN
                step = {f[0], f[31:1]};
`else
                step = f;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            f     <= 32'h0;
            cnt   <= 5'd0;
            op_q  <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        f     <= in;
                        op_q  <= op;
                        cnt   <= eff_amt;
                        state <= (eff_amt != 5'd0) ? S_SHIFT : S_DONE;
                    end
                end
                S_SHIFT: begin
                    f   <= step;
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign dbg_state = state;

endmodule
